// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide memory read path.
// FSM state encoding, byte-select values and default sizing.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_LO,
        RD_HI,
        RESP
    } state_t;

    localparam logic BYTE_LO = 1'b0;
    localparam logic BYTE_HI = 1'b1;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting the search at ptr.
// Pointer advances past the served requester on grant_accept; no backpressure of its own.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_accept,
    input  logic [IDX_W-1:0]   accept_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [IDX_W-1:0] ptr_q;
    int               k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        k         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            k = int'(ptr_q) + off;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!any_grant && req[k]) begin
                any_grant = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (grant_accept) begin
            ptr_q <= (accept_idx == IDX_W'(NUM_REQ - 1)) ? '0 : accept_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares a byte-wide memory among requesters; reads lo then hi byte, acks with {hi,lo}.
// Latency: ack 4 cycles after req is sampled in IDLE; one word per 5 cycles; requesters hold req until ack.
module mem_read_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int ADDR_W  = DEF_ADDR_W,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        ack,
    output logic [15:0]               rsp_data,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_cs,
    output logic                      mem_byte_sel,
    input  logic [7:0]                mem_data
);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_grant;
    logic               latch_req;
    logic               grant_accept;
    logic [IDX_W-1:0]   owner_q;
    logic [7:0]         lo_q;
    logic [ADDR_W-1:0]  sel_addr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .grant_accept (grant_accept),
        .accept_idx   (owner_q),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .any_grant    (any_grant)
    );

    // Grant is one-hot, so an AND-OR mux picks the winner's address slice.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_cs       = 1'b0;
        mem_byte_sel = BYTE_LO;
        busy         = 1'b1;
        latch_req    = 1'b0;
        grant_accept = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (any_grant) begin
                    latch_req = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                state_d = RD_LO;
            end
            RD_LO: begin
                mem_cs       = 1'b1;
                mem_byte_sel = BYTE_LO;
                state_d      = RD_HI;
            end
            RD_HI: begin
                mem_cs       = 1'b1;
                mem_byte_sel = BYTE_HI;
                state_d      = RESP;
            end
            RESP: begin
                grant_accept = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ack and rsp_data are registered off the RD_HI edge so they land exactly in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr <= '0;
            owner_q  <= '0;
            lo_q     <= '0;
            rsp_data <= '0;
            ack      <= '0;
        end else begin
            ack <= '0;
            if (latch_req) begin
                mem_addr <= sel_addr;
                owner_q  <= grant_idx;
            end
            if (state_q == RD_LO) begin
                lo_q <= mem_data;
            end
            if (state_q == RD_HI) begin
                rsp_data <= {mem_data, lo_q};
                ack      <= NUM_REQ'(1) << owner_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a queue-based scoreboard and a memory model.
module tb_mem_read_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_addr;
    logic [1:0]  ack;
    logic [15:0] rsp_data;
    logic        busy;
    logic [7:0]  mem_addr;
    logic        mem_cs;
    logic        mem_byte_sel;
    logic [7:0]  mem_data;

    logic [15:0] mem_word_q;

    typedef struct {
        int          idx;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_chk;
    int   n_fail;

    mem_read_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_addr     (req_addr),
        .ack          (ack),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_cs       (mem_cs),
        .mem_byte_sel (mem_byte_sel),
        .mem_data     (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory preload mem[i] = 0x000A + i, word registered from mem_addr every edge.
    always @(posedge clk) mem_word_q <= 16'h000A + {8'h00, mem_addr};
    assign mem_data = mem_cs ? (mem_byte_sel ? mem_word_q[15:8] : mem_word_q[7:0]) : 8'hEE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [15:0] data, input int at);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every ack against the scoreboard head, flags missed acks.
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL ack_missing: req %0d due cycle %0d not seen", exp_q[0].idx, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (ack != 2'b00) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL ack_unexpected: got ack %b data %h (cycle %0d)", ack, rsp_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_vec", 32'(ack), 32'(2'b01 << e.idx));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        int k;
        n_chk    = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        req      = 2'b00;
        req_addr = 16'h0000;
        tick(3);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rsp", 32'(rsp_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_cs", 32'(mem_cs), 32'h0);
        chk("rst_sel", 32'(mem_byte_sel), 32'h0);
        reset = 1'b0;
        tick(2);

        // Single read, requester 0, address 0x05.
        k = cyc;
        req = 2'b01; req_addr = 16'h0005;
        push(0, 16'h000F, k + 4);
        tick(1);
        chk("setup_cs", 32'(mem_cs), 32'h0);
        chk("setup_busy", 32'(busy), 32'h1);
        chk("setup_addr", 32'(mem_addr), 32'h05);
        tick(1);
        chk("rdlo_cs_sel", 32'({mem_cs, mem_byte_sel}), 32'b10);
        tick(1);
        chk("rdhi_cs_sel", 32'({mem_cs, mem_byte_sel}), 32'b11);
        tick(1);
        chk("resp_cs", 32'(mem_cs), 32'h0);
        req = 2'b00;
        tick(2);

        // Byte order at the top of memory, requester 1.
        k = cyc;
        req = 2'b10; req_addr = 16'hF600;
        push(1, 16'h0100, k + 4);
        tick(4);
        req = 2'b00;
        tick(2);
        k = cyc;
        req = 2'b10; req_addr = 16'hFF00;
        push(1, 16'h0109, k + 4);
        tick(4);
        req = 2'b00;
        tick(2);

        // Contention: both held, strict alternation starting at requester 0.
        k = cyc;
        req = 2'b11; req_addr = 16'h1000;
        push(0, 16'h000A, k + 4);
        push(1, 16'h001A, k + 9);
        push(0, 16'h000A, k + 14);
        push(1, 16'h001A, k + 19);
        tick(19);
        req = 2'b00;
        tick(2);

        // Late arrival: requester 1 raises req during requester 0's RD_LO.
        k = cyc;
        req = 2'b01; req_addr = 16'h3007;
        push(0, 16'h0011, k + 4);
        tick(2);
        req = 2'b11;
        push(1, 16'h003A, k + 9);
        tick(2);
        req = 2'b10;
        tick(5);
        req = 2'b00;
        tick(2);

        // Reset during RD_HI aborts; held request is served again afterwards.
        k = cyc;
        req = 2'b01; req_addr = 16'h0020;
        tick(3);
        chk("pre_rst_rdhi", 32'({mem_cs, mem_byte_sel}), 32'b11);
        reset = 1'b1;
        tick(1);
        chk("midrst_ack", 32'(ack), 32'h0);
        chk("midrst_cs", 32'(mem_cs), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_addr", 32'(mem_addr), 32'h0);
        chk("midrst_rsp", 32'(rsp_data), 32'h0);
        reset = 1'b0;
        k = cyc;
        push(0, 16'h002A, k + 4);
        tick(4);
        req = 2'b00;
        tick(2);

        // Idle bus.
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle_ack_cs_busy", 32'({ack, mem_cs, busy}), 32'h0);
        end

        tick(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
